// File: rtl/counter_prog.sv
// counter_prog: programmable up/down counter used as a timer / event-count
// primitive (interval timers, PWM period generators).
//
// Counts over the range 0..limit by a variable step, with three boundary
// behaviours selected by mode: wrap (modulo), saturate, and one-shot.
// A one-shot boundary parks the counter in HALT with done=1 until clr or
// load. Per-cycle priority is clr > load > count.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (clears all state)
//   en       in   count enable
//   up_dn    in   1 = count up, 0 = count down
//   clr      in   synchronous clear
//   load     in   synchronous load of load_val (loaded as-is, even > limit)
//   load_val in   [N]      value to load
//   limit    in   [N]      terminal value
//   mode     in   [2]      00 wrap, 01 saturate, 10 one-shot, 11 as wrap
//   step     in   [STEP_W] amount per enabled cycle
//   counter  out  [N]      current count (registered)
//   tc       out           terminal-count pulse (registered, one cycle)
//   done     out           one-shot completion flag (registered level)
module counter_prog #(
  parameter int N      = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              clr,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic [N-1:0]      limit,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  output logic [N-1:0]      counter,
  output logic              tc,
  output logic              done
);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  // Up-direction wrap. r = sum - (limit+1) is the overshoot past the top.
  // If the step jumps more than a full period (step > limit+1) a single
  // subtraction cannot land in range, so the counter restarts at 0; this
  // is also what keeps limit=0 pinned at 0.
  function automatic logic [N-1:0] wrap_up(input logic [N:0]   sum,
                                           input logic [N:0]   lim1,
                                           input logic [N-1:0] cnt,
                                           input logic [N-1:0] stp,
                                           input logic [N-1:0] lim);
    logic [N:0] r;
    r = sum - lim1;
    if (r >= lim1) return '0;
    // r fits in range, so the N-bit modular form gives the same value
    return cnt + stp - lim - N'(1);
  endfunction

  // Down-direction wrap: counter + limit + 1 - step. base is the
  // non-aliasing N+1 bit value of counter + limit + 1; when the step is
  // larger than that the counter restarts at 0 instead of aliasing.
  function automatic logic [N-1:0] wrap_dn(input logic [N:0]   base,
                                           input logic [N:0]   stp_x,
                                           input logic [N-1:0] cnt,
                                           input logic [N-1:0] stp,
                                           input logic [N-1:0] lim);
    if (base < stp_x) return '0;
    return cnt + lim + N'(1) - stp;
  endfunction

  logic [N:0]   cnt_x, lim_x, lim1_x, stp_x, sum_x, base_x;
  logic [N-1:0] step_n;
  logic [N-1:0] nxt;
  logic         evt;
  logic         shot;
  logic         count_ok;

  always_comb begin
    step_n  = {{(N-STEP_W){1'b0}}, step};
    cnt_x   = {1'b0, counter};
    lim_x   = {1'b0, limit};
    stp_x   = {1'b0, step_n};
    lim1_x  = lim_x + (N+1)'(1);
    sum_x   = cnt_x + stp_x;
    base_x  = cnt_x + lim1_x;
    nxt     = counter;
    evt     = 1'b0;
    shot    = 1'b0;

    if (up_dn) begin
      if (sum_x > lim_x) begin
        evt = 1'b1;
        if (mode == MODE_SAT || mode == MODE_ONE) begin
          nxt  = limit;
          shot = (mode == MODE_ONE);
        end else if (cnt_x <= lim_x) begin
          nxt = wrap_up(sum_x, lim1_x, counter, step_n, limit);
        end else begin
          nxt = '0;
        end
      end else begin
        nxt = sum_x[N-1:0];
      end
    end else begin
      if (cnt_x > lim_x) begin
        // Out of range after a limit change or oversized load: snap to top.
        evt = 1'b1;
        nxt = limit;
      end else if (cnt_x >= stp_x) begin
        nxt = counter - step_n;
      end else begin
        evt = 1'b1;
        if (mode == MODE_SAT || mode == MODE_ONE) begin
          nxt  = '0;
          shot = (mode == MODE_ONE);
        end else begin
          nxt = wrap_dn(base_x, stp_x, counter, step_n, limit);
        end
      end
    end

    count_ok = (state == RUN) && en && (step != '0);
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      counter <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (clr) begin
      state   <= RUN;
      counter <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      state   <= RUN;
      counter <= load_val;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (count_ok) begin
      counter <= nxt;
      tc      <= evt;
      if (shot) begin
        done  <= 1'b1;
        state <= HALT;
      end
    end else begin
      // Holding (en=0, step=0 or HALT): counter and done keep their values
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// Testbench for counter_prog (N=8, STEP_W=4). Directed vectors push their
// expected counter/tc/done into a queue; an independent monitor pops one
// entry after each rising edge (or after an asynchronous-reset probe) and
// compares it against the DUT outputs.
module tb_counter_prog;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  load_val = '0;
  logic [N-1:0]  limit = '0;
  logic [1:0]    mode = 2'b00;
  logic [SW-1:0] step = '0;
  logic [N-1:0]  counter;
  logic          tc;
  logic          done;

  counter_prog #(.N(N), .STEP_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .step     (step),
    .counter  (counter),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] c;
    logic         t;
    logic         d;
    string        nm;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad = 0;
  string tag = "reset";
  event  ev_sample;

  // Called at a falling edge: queue the expectation for the next rising edge.
  task automatic tick(input logic [N-1:0] c, input logic t, input logic d);
    exp_t e;
    e.c = c; e.t = t; e.d = d; e.nm = tag;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expectation checked without waiting for a clock edge.
  task automatic async_chk(input logic [N-1:0] c, input logic t, input logic d);
    exp_t e;
    e.c = c; e.t = t; e.d = d; e.nm = tag;
    q.push_back(e);
    ->ev_sample;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_sample);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (counter !== e.c || tc !== e.t || done !== e.d) begin
          bad++;
          $display("FAIL %s: got counter=%0d tc=%0b done=%0b, want counter=%0d tc=%0b done=%0b",
                   e.nm, counter, tc, done, e.c, e.t, e.d);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, pending=%0d want 0", q.size());
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    tag = "reset";
    async_chk(8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Basic full-range wrap, step 1
    tag = "basic";
    limit = 8'd255; mode = 2'b00; up_dn = 1'b1; step = 4'd1; en = 1'b1;
    for (int i = 1; i <= 256; i++) tick(8'(i % 256), (i == 256), 1'b0);

    // Modulo wrap with step 3, limit 9
    tag = "wrap_up";
    limit = 8'd9; step = 4'd3;
    clr = 1'b1; tick(8'd0, 1'b0, 1'b0); clr = 1'b0;
    tick(8'd3, 1'b0, 1'b0);
    tick(8'd6, 1'b0, 1'b0);
    tick(8'd9, 1'b0, 1'b0);
    tick(8'd2, 1'b1, 1'b0);
    tick(8'd5, 1'b0, 1'b0);
    tick(8'd8, 1'b0, 1'b0);
    tick(8'd1, 1'b1, 1'b0);
    tag = "wrap_dn";
    up_dn = 1'b0;
    tick(8'd8, 1'b1, 1'b0);
    tick(8'd5, 1'b0, 1'b0);
    tick(8'd2, 1'b0, 1'b0);
    tick(8'd9, 1'b1, 1'b0);

    // Saturate
    tag = "sat_up";
    mode = 2'b01; limit = 8'd200; step = 4'd4; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd198; tick(8'd198, 1'b0, 1'b0); load = 1'b0;
    tick(8'd200, 1'b1, 1'b0);
    tick(8'd200, 1'b1, 1'b0);
    tick(8'd200, 1'b1, 1'b0);
    tag = "sat_dn";
    up_dn = 1'b0;
    tick(8'd196, 1'b0, 1'b0);
    load = 1'b1; load_val = 8'd2; tick(8'd2, 1'b0, 1'b0); load = 1'b0;
    tick(8'd0, 1'b1, 1'b0);
    tick(8'd0, 1'b1, 1'b0);

    // One-shot
    tag = "oneshot";
    mode = 2'b10; limit = 8'd5; step = 4'd2; up_dn = 1'b1;
    clr = 1'b1; tick(8'd0, 1'b0, 1'b0); clr = 1'b0;
    tick(8'd2, 1'b0, 1'b0);
    tick(8'd4, 1'b0, 1'b0);
    tick(8'd5, 1'b1, 1'b1);
    tag = "halt_hold";
    for (int i = 0; i < 10; i++) tick(8'd5, 1'b0, 1'b1);
    mode = 2'b00; tick(8'd5, 1'b0, 1'b1); mode = 2'b10;
    tag = "halt_load";
    load = 1'b1; load_val = 8'd0; tick(8'd0, 1'b0, 1'b0); load = 1'b0;
    tick(8'd2, 1'b0, 1'b0);

    // Priority and holds
    tag = "clr_vs_load";
    mode = 2'b00; limit = 8'd200;
    clr = 1'b1; load = 1'b1; load_val = 8'd77; tick(8'd0, 1'b0, 1'b0); clr = 1'b0;
    load_val = 8'd50; tick(8'd50, 1'b0, 1'b0); load = 1'b0;
    tag = "en_off";
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick(8'd50, 1'b0, 1'b0);
    tag = "step_zero";
    en = 1'b1; step = 4'd0;
    for (int i = 0; i < 5; i++) tick(8'd50, 1'b0, 1'b0);
    tag = "out_of_range";
    limit = 8'd100; step = 4'd1;
    load = 1'b1; load_val = 8'd250; tick(8'd250, 1'b0, 1'b0); load = 1'b0;
    up_dn = 1'b0;
    tick(8'd100, 1'b1, 1'b0);
    tick(8'd99, 1'b0, 1'b0);

    // limit = 0
    tag = "limit_zero";
    limit = 8'd0;
    clr = 1'b1; tick(8'd0, 1'b0, 1'b0); clr = 1'b0;
    up_dn = 1'b1; step = 4'd3;
    tick(8'd0, 1'b1, 1'b0);
    tick(8'd0, 1'b1, 1'b0);
    up_dn = 1'b0; step = 4'd1;
    tick(8'd0, 1'b1, 1'b0);
    mode = 2'b01; up_dn = 1'b1;
    tick(8'd0, 1'b1, 1'b0);

    // Async reset mid-count (wrap)
    tag = "async_count";
    mode = 2'b00; limit = 8'd255; step = 4'd1; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd36; tick(8'd36, 1'b0, 1'b0); load = 1'b0;
    tick(8'd37, 1'b0, 1'b0);
    en = 1'b0;
    #2 rst = 1'b0;
    async_chk(8'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    tag = "restart";
    en = 1'b1;
    tick(8'd1, 1'b0, 1'b0);

    // Async reset while halted
    tag = "async_halt";
    mode = 2'b10; limit = 8'd5; step = 4'd2;
    clr = 1'b1; tick(8'd0, 1'b0, 1'b0); clr = 1'b0;
    tick(8'd2, 1'b0, 1'b0);
    tick(8'd4, 1'b0, 1'b0);
    tick(8'd5, 1'b1, 1'b1);
    tick(8'd5, 1'b0, 1'b1);
    en = 1'b0;
    #2 rst = 1'b0;
    async_chk(8'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    tag = "restart_halt";
    en = 1'b1;
    tick(8'd2, 1'b0, 1'b0);

    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
